// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data memory controller.
// Size and FSM encodings plus the alignment rule.
package dmem_pkg;

    localparam int MEM_AW = 10;
    localparam int ADDR_W = 12;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD_RSP,
        S_WR,
        S_ERR
    } state_e;

    // Reserved size is always rejected; otherwise natural alignment.
    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        logic m;
        m = 1'b1;
        unique case (sz)
            SZ_B:    m = 1'b0;
            SZ_H:    m = lo[0];
            SZ_W:    m = |lo;
            default: m = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte/half lane extraction with extension for loads,
// and read-modify-write lane merge for sub-word stores.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [4:0]  sh_b;
    logic [4:0]  sh_h;

    assign sh_b = {addr_lo, 3'b000};
    assign sh_h = {addr_lo[1], 4'b0000};

    // Pick the addressed lane and extend it to a full word
    always_comb begin
        lane_b  = rdata[sh_b +: 8];
        lane_h  = rdata[sh_h +: 16];
        ld_data = rdata;
        unique case (size)
            SZ_B:    ld_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SZ_H:    ld_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default: ld_data = rdata;
        endcase
    end

    // Replace only the addressed lane; full words pass straight through
    always_comb begin
        st_data = rdata;
        unique case (size)
            SZ_B:    st_data[sh_b +: 8]  = wdata[7:0];
            SZ_H:    st_data[sh_h +: 16] = wdata[15:0];
            default: st_data = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: CPU load/store front end to a registered-read word memory.
// Sub-word stores do a read-modify-write; misaligned accesses error out.
module dmem_ctrl
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [11:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misaligned,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e              state_q, state_d;
    logic [11:0]         addr_q, addr_d;
    size_e               size_q, size_d;
    logic                uns_q, uns_d;
    logic                write_q, write_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                mis_q, mis_d;
    logic                we_q, we_d;
    logic [MEM_AW-1:0]   maddr_q, maddr_d;
    logic [31:0]         ld_data;
    logic [31:0]         st_data;
    logic                accept;
    size_e               req_sz;

    assign req_sz = size_e'(req_size);
    assign accept = req_valid & ready_q;

    // Next state, request capture and registered output decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        write_d = write_q;
        wdata_d = wdata_q;
        if (accept) begin
            addr_d  = req_addr;
            size_d  = req_sz;
            uns_d   = req_unsigned;
            write_d = req_write;
            wdata_d = req_wdata;
        end
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misaligned(req_sz, req_addr[1:0])) begin
                        state_d = S_ERR;
                    end else if (req_write && req_sz == SZ_W) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:     state_d = write_q ? S_WR : S_LD_RSP;
            S_LD_RSP: state_d = S_IDLE;
            S_WR:     state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_LD_RSP) || (state_d == S_WR) ||
                      (state_d == S_ERR);
        mis_d       = (state_d == S_ERR);
        we_d        = (state_d == S_WR);
        maddr_d     = '0;
        if (state_d == S_RD || state_d == S_LD_RSP || state_d == S_WR) begin
            maddr_d = addr_d[11:2];
        end
    end

    // FSM and capture registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            mis_q       <= 1'b0;
            we_q        <= 1'b0;
            maddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            mis_q       <= mis_d;
            we_q        <= we_d;
            maddr_q     <= maddr_d;
        end
    end

    dmem_lane_align u_lane (
        .size        (size_q),
        .is_unsigned (uns_q),
        .addr_lo     (addr_q[1:0]),
        .rdata       (mem_rdata),
        .wdata       (wdata_q),
        .ld_data     (ld_data),
        .st_data     (st_data)
    );

    assign req_ready      = ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_misaligned = mis_q;
    assign mem_we         = we_q;
    assign mem_addr       = maddr_q;
    assign rsp_rdata      = (state_q == S_LD_RSP) ? ld_data : '0;
    assign mem_wdata      = (state_q == S_WR) ? st_data : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: random and directed accesses against a word-array model.
// The bench also plays the registered-read data memory.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic        sync_req;
    int          total;
    int          bad;
    int          we_cnt;
    int          exp_we;
    logic [31:0] last_rd;

    dmem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory; sync_req loads it from the model image
    always @(posedge clk) begin
        if (sync_req) begin
            for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
        end else begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_mem();
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
    endtask

    function automatic logic is_mis(input logic [11:0] a, input int sz);
        if (sz == 3) return 1'b1;
        if (sz == 1) return (a % 2) != 0;
        if (sz == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [11:0] a,
                                             input int sz, input logic u);
        logic [31:0] w, v;
        int sh;
        w = ref_mem[a / 4];
        if (sz == 0) begin
            sh = (a % 4) * 8;
            v = (w >> sh) & 32'hFF;
            if (!u && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            sh = ((a % 4) / 2) * 16;
            v = (w >> sh) & 32'hFFFF;
            if (!u && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [11:0] a,
                                              input int sz,
                                              input logic [31:0] d);
        logic [31:0] w, m;
        int sh;
        w = ref_mem[a / 4];
        if (sz == 2) return d;
        if (sz == 0) begin
            sh = (a % 4) * 8;
            m = 32'hFF << sh;
        end else begin
            sh = ((a % 4) / 2) * 16;
            m = 32'hFFFF << sh;
        end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    task automatic do_req(input logic w, input logic [11:0] a, input int sz,
                          input logic u, input logic [31:0] d);
        logic        mis;
        int          lat;
        int          k;
        logic [31:0] nw;
        req_write    = w;
        req_addr     = a;
        req_size     = 2'(sz);
        req_unsigned = u;
        req_wdata    = d;
        req_valid    = 1'b1;
        chk("ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        mis = is_mis(a, sz);
        lat = (mis || (w && sz == 2)) ? 1 : 2;
        k = 1;
        while (!rsp_valid && k < 6) begin
            tick();
            k++;
        end
        chk("latency", k, lat);
        if (rsp_valid) begin
            chk("mis_flag", rsp_misaligned, mis);
            if (mis) begin
                chk("err_rdata", rsp_rdata, 0);
                chk("err_we", mem_we, 0);
                chk("err_addr", mem_addr, 0);
            end else if (w) begin
                nw = ref_store(a, sz, d);
                chk("st_we", mem_we, 1);
                chk("st_addr", mem_addr, a / 4);
                chk("st_wdata", mem_wdata, nw);
                chk("st_rdata", rsp_rdata, 0);
                ref_mem[a / 4] = nw;
                exp_we++;
            end else begin
                chk("ld_rdata", rsp_rdata, ref_load(a, sz, u));
                chk("ld_we", mem_we, 0);
                chk("ld_addr", mem_addr, a / 4);
                last_rd = rsp_rdata;
            end
        end
        tick();
        chk("rsp_pulse", rsp_valid, 0);
        chk("idle_addr", mem_addr, 0);
        chk("idle_ready", req_ready, 1);
    endtask

    initial begin
        int nmis;
        total = 0;
        bad = 0;
        we_cnt = 0;
        exp_we = 0;
        last_rd = '0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_size = '0;
        req_unsigned = 1'b0;
        req_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        rst = 1'b1;
        sync_req = 1'b1;
        tick();
        tick();
        sync_req = 1'b0;
        rst = 1'b0;

        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mis", rsp_misaligned, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);

        do_req(1'b1, 12'h010, 2, 1'b0, 32'hDEADBEEF);
        chk("sw_mem", mem[4], 32'hDEADBEEF);

        ref_mem[4] = 32'h11223344;
        sync_mem();
        do_req(1'b1, 12'h013, 0, 1'b0, 32'h000000A5);
        chk("sb_mem", mem[4], 32'hA5223344);

        ref_mem[4] = 32'h0080FF00;
        sync_mem();
        do_req(1'b0, 12'h012, 0, 1'b0, 32'h0);
        chk("lb_val", last_rd, 32'hFFFFFF80);
        do_req(1'b0, 12'h012, 0, 1'b1, 32'h0);
        chk("lbu_val", last_rd, 32'h00000080);

        do_req(1'b0, 12'h001, 1, 1'b0, 32'h0);
        do_req(1'b1, 12'h003, 3, 1'b0, 32'h0);

        // reset while a half store sits in RD
        req_write = 1'b1;
        req_addr = 12'h022;
        req_size = 2'd1;
        req_unsigned = 1'b0;
        req_wdata = 32'h0000BEEF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rstmid_we_rd", mem_we, 0);
        chk("rstmid_rsp_rd", rsp_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_rsp", rsp_valid, 0);
        chk("rstmid_we", mem_we, 0);
        chk("rstmid_ready", req_ready, 1);
        chk("rstmid_addr", mem_addr, 0);
        tick();
        chk("rstmid_rsp2", rsp_valid, 0);
        chk("rstmid_we2", mem_we, 0);

        // back-to-back loads with req_valid held high
        req_write = 1'b0;
        req_addr = 12'h020;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        req_valid = 1'b1;
        chk("b2b_rdy0", req_ready, 1);
        tick();
        chk("b2b_rdy1", req_ready, 0);
        req_addr = 12'h036;
        req_size = 2'd1;
        req_unsigned = 1'b1;
        tick();
        chk("b2b_rdy2", req_ready, 0);
        chk("b2b_rsp1", rsp_valid, 1);
        chk("b2b_rd1", rsp_rdata, ref_load(12'h020, 2, 1'b0));
        tick();
        chk("b2b_rdy3", req_ready, 1);
        tick();
        chk("b2b_acc2", req_ready, 0);
        req_valid = 1'b0;
        tick();
        chk("b2b_rsp2", rsp_valid, 1);
        chk("b2b_rd2", rsp_rdata, ref_load(12'h036, 1, 1'b1));
        tick();
        chk("b2b_idle", req_ready, 1);

        for (int n = 0; n < 300; n++) begin
            logic [11:0] a;
            a = 12'($urandom);
            if ($urandom_range(0, 1) == 0) a = a & 12'h03F;
            do_req(1'($urandom), a, int'($urandom_range(0, 3)),
                   1'($urandom), $urandom);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        chk("we_count", we_cnt, exp_we);
        nmis = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nmis++;
        chk("mem_final", nmis, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
